tristate_bus_arbiter: RTL and testbench

- Shares one tristate bus between N requesters.
- Grants ownership round-robin and produces one-hot output enables for the per-source tristate drivers, so no two sources ever drive the bus at once.
- Inserts a configurable turnaround gap with all enables low between owners.
- Forces release after a maximum hold time.
- Sits between the requesting datapath units and the bank of single-bit tristate buffers on the shared bus.

---
 rtl/tristate_bus_arbiter.sv | 107 ++++++++++
 tb/tb_tristate_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus.
// Produces one-hot drive enables with a turnaround gap and a hold limit.
module tristate_bus_arbiter #(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   oe,
  output logic [IDW-1:0] owner,
  output logic           busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [HW-1:0]  hold;
  logic [TW-1:0]  turn;
  logic [IDW-1:0] win;
  logic           found;
  logic [N-1:0]   win_oh;

  // Search starts just past the previous owner, so it ranks lowest.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (int'(last) + i) % N;
      if (!found && req[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign win_oh = {{(N-1){1'b0}}, 1'b1} << win;
  assign oe     = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      busy  <= 1'b0;
      last  <= IDW'(N - 1);
      hold  <= '0;
      turn  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            grant <= win_oh;
            owner <= win;
            last  <= win;
            hold  <= '0;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (!req[owner] || hold == HW'(MAX_HOLD - 1)) begin
            state <= TURN;
            grant <= '0;
            turn  <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        TURN: begin
          if (turn == TW'(TURN_CYCLES - 1)) begin
            if (found) begin
              state <= GRANT;
              grant <= win_oh;
              owner <= win;
              last  <= win;
              hold  <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            turn <= turn + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random traffic
// checked against an ownership-level model, on two turnaround settings.
module tb_tristate_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int TA = 1;
  localparam int TB = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b, oe_a, oe_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(
    .N(N), .IDW(2), .MAX_HOLD(MH), .TURN_CYCLES(TA)
  ) u_a (
    .clk(clk), .reset(reset), .req(req_a), .grant(grant_a),
    .oe(oe_a), .owner(owner_a), .busy(busy_a)
  );

  tristate_bus_arbiter #(
    .N(N), .IDW(2), .MAX_HOLD(MH), .TURN_CYCLES(TB)
  ) u_b (
    .clk(clk), .reset(reset), .req(req_b), .grant(grant_b),
    .oe(oe_b), .owner(owner_b), .busy(busy_b)
  );

  logic [3:0] g_v[2];
  logic [3:0] o_v[2];
  logic [1:0] w_v[2];
  logic       b_v[2];
  assign g_v[0] = grant_a;
  assign g_v[1] = grant_b;
  assign o_v[0] = oe_a;
  assign o_v[1] = oe_b;
  assign w_v[0] = owner_a;
  assign w_v[1] = owner_b;
  assign b_v[0] = busy_a;
  assign b_v[1] = busy_b;

  // Ownership model: who holds the bus, for how long, and gap remaining.
  typedef struct {
    int own;
    int last;
    int held;
    int gap;
    bit active;
    bit busy;
  } mdl_t;

  mdl_t m[2];

  function automatic int tcy(int k);
    return (k == 0) ? TA : TB;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].own    = 0;
      m[k].last   = N - 1;
      m[k].held   = 0;
      m[k].gap    = 0;
      m[k].active = 1'b0;
      m[k].busy   = 1'b0;
    end
  endfunction

  function automatic void m_pick(int k, logic [3:0] r);
    for (int j = 1; j <= N; j++) begin
      int c;
      c = (m[k].last + j) % N;
      if (r[c]) begin
        m[k].own    = c;
        m[k].last   = c;
        m[k].held   = 0;
        m[k].active = 1'b1;
        m[k].busy   = 1'b1;
        return;
      end
    end
    m[k].busy = 1'b0;
  endfunction

  function automatic void m_step(int k, logic [3:0] r);
    if (m[k].active) begin
      m[k].held++;
      if (!r[m[k].own] || m[k].held == MH) begin
        m[k].active = 1'b0;
        m[k].gap    = tcy(k);
      end
    end else if (m[k].gap > 0) begin
      m[k].gap--;
      if (m[k].gap == 0) m_pick(k, r);
    end else begin
      m_pick(k, r);
    end
  endfunction

  function automatic logic [3:0] exp_g(int k);
    logic [3:0] one;
    one = 4'b0001;
    return m[k].active ? (one << m[k].own) : 4'b0000;
  endfunction

  task automatic step(input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    m_step(0, ra);
    m_step(1, rb);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    m_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g_v[k] !== 4'b0 || o_v[k] !== 4'b0) begin
        errors++;
        $display("FAIL reset_en[%0d]: got g=%b oe=%b want 0", k, g_v[k], o_v[k]);
      end
      checks++;
      if (b_v[k] !== 1'b0 || w_v[k] !== 2'd0) begin
        errors++;
        $display("FAIL reset_st[%0d]: got busy=%b own=%0d want 0/0", k, b_v[k], w_v[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_handshake();
    for (int c = 0; c < 3; c++) begin
      step(4'b0100, 4'b0);
      checks++;
      if (grant_a !== 4'b0100 || oe_a !== 4'b0100 || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL hs_grant c%0d: got g=%b oe=%b busy=%b want 0100/0100/1", c, grant_a, oe_a, busy_a);
      end
    end
    step(4'b0, 4'b0);
    checks++;
    if (grant_a !== 4'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL hs_turn: got g=%b busy=%b want 0000/1", grant_a, busy_a);
    end
    step(4'b0, 4'b0);
    checks++;
    if (grant_a !== 4'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL hs_idle: got g=%b busy=%b want 0000/0", grant_a, busy_a);
    end
  endtask

  task automatic test_priority();
    step(4'b0101, 4'b0);
    checks++;
    if (grant_a !== 4'b0001 || owner_a !== 2'd0) begin
      errors++;
      $display("FAIL prio_after2: got g=%b own=%0d want 0001/0", grant_a, owner_a);
    end
    step(4'b0, 4'b0);
    step(4'b0, 4'b0);
    step(4'b0101, 4'b0);
    checks++;
    if (grant_a !== 4'b0100 || owner_a !== 2'd2) begin
      errors++;
      $display("FAIL prio_after0: got g=%b own=%0d want 0100/2", grant_a, owner_a);
    end
    step(4'b0, 4'b0);
    step(4'b0, 4'b0);
  endtask

  task automatic test_reset_mid_grant();
    step(4'b0001, 4'b0);
    step(4'b0001, 4'b0);
    checks++;
    if (grant_a !== 4'b0001) begin
      errors++;
      $display("FAIL mid_pre: got g=%b want 0001", grant_a);
    end
    reset = 1'b1;
    req_a = 4'b0;
    #1;
    m_reset();
    checks++;
    if (grant_a !== 4'b0 || oe_a !== 4'b0 || owner_a !== 2'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got g=%b oe=%b own=%0d busy=%b want 0/0/0/0", grant_a, oe_a, owner_a, busy_a);
    end
    @(negedge clk);
    reset = 1'b0;
    req_a = 4'b0001;
    @(posedge clk);
    m_step(0, 4'b0001);
    m_step(1, 4'b0);
    #1;
    checks++;
    if (grant_a !== 4'b0001 || oe_a !== 4'b0001) begin
      errors++;
      $display("FAIL mid_regrant: got g=%b oe=%b want 0001", grant_a, oe_a);
    end
    step(4'b0, 4'b0);
    step(4'b0, 4'b0);
  endtask

  task automatic test_fairness();
    do_reset();
    for (int g = 0; g < 5; g++) begin
      logic [3:0] want;
      want = 4'b0001 << (g % 4);
      for (int c = 0; c < MH; c++) begin
        step(4'b1111, 4'b0);
        checks++;
        if (grant_a !== want) begin
          errors++;
          $display("FAIL fair g%0d c%0d: got %b want %b", g, c, grant_a, want);
        end
      end
      if (g < 4) begin
        step(4'b1111, 4'b0);
        checks++;
        if (grant_a !== 4'b0 || oe_a !== 4'b0) begin
          errors++;
          $display("FAIL fair_gap g%0d: got g=%b oe=%b want 0", g, grant_a, oe_a);
        end
      end
    end
    repeat (3) step(4'b0, 4'b0);
  endtask

  task automatic test_forced_release();
    for (int c = 0; c < 30; c++) begin
      logic [3:0] want;
      want = ((c % 10) < MH) ? 4'b0010 : 4'b0000;
      step(4'b0, 4'b0010);
      checks++;
      if (grant_b !== want) begin
        errors++;
        $display("FAIL force c%0d: got %b want %b", c, grant_b, want);
      end
      if (want == 4'b0) begin
        checks++;
        if (oe_b[1] !== 1'b0) begin
          errors++;
          $display("FAIL force_oe c%0d: got oe1=%b want 0", c, oe_b[1]);
        end
      end
    end
    repeat (3) step(4'b0, 4'b0);
  endtask

  task automatic test_random();
    logic [3:0] r[2];
    int prev[2];
    int zrun[2];
    r[0] = '0;
    r[1] = '0;
    prev[0] = -1;
    prev[1] = -1;
    zrun[0] = 0;
    zrun[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 5) == 0) r[k][b] = ~r[k][b];
      step(r[0], r[1]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (g_v[k] !== exp_g(k)) begin
          errors++;
          $display("FAIL rnd_grant[%0d] c%0d: got %b want %b", k, c, g_v[k], exp_g(k));
        end
        checks++;
        if (o_v[k] !== exp_g(k)) begin
          errors++;
          $display("FAIL rnd_oe[%0d] c%0d: got %b want %b", k, c, o_v[k], exp_g(k));
        end
        checks++;
        if (int'(w_v[k]) != m[k].own) begin
          errors++;
          $display("FAIL rnd_owner[%0d] c%0d: got %0d want %0d", k, c, w_v[k], m[k].own);
        end
        checks++;
        if (b_v[k] !== m[k].busy) begin
          errors++;
          $display("FAIL rnd_busy[%0d] c%0d: got %b want %b", k, c, b_v[k], m[k].busy);
        end
        checks++;
        if (!$onehot0(g_v[k])) begin
          errors++;
          $display("FAIL rnd_onehot[%0d] c%0d: got %b want onehot0", k, c, g_v[k]);
        end
        if (o_v[k] == 4'b0) begin
          zrun[k]++;
        end else begin
          int o;
          o = $clog2(o_v[k]);
          if (prev[k] >= 0 && o != prev[k]) begin
            checks++;
            if (zrun[k] < tcy(k)) begin
              errors++;
              $display("FAIL rnd_gap[%0d] c%0d: got %0d idle want >=%0d", k, c, zrun[k], tcy(k));
            end
          end
          prev[k] = o;
          zrun[k] = 0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_priority();
    test_reset_mid_grant();
    test_fairness();
    test_forced_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
